// File: rtl/mem_arb_if.sv
// Bundle of the two requester ports and the memory port of mem_arb.
// slave  : the arbiter's view (requests in, grants/read data out, memory port out).
// master : the environment's view (mirror image of slave).
// Handshake: a requester holds mX_req (with we/lock/addr/wdata) for a cycle;
// the access is accepted in that same cycle exactly when mX_gnt is high.
// Read data for an accepted read appears on mX_rdata with mX_rvalid high on
// the following cycle.
interface mem_arb_if;
   logic        m0_req;
   logic        m0_we;
   logic        m0_lock;
   logic [15:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_gnt;
   logic [31:0] m0_rdata;
   logic        m0_rvalid;

   logic        m1_req;
   logic        m1_we;
   logic        m1_lock;
   logic [15:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_gnt;
   logic [31:0] m1_rdata;
   logic        m1_rvalid;

   logic [15:0] addr;
   logic [31:0] dataW;
   logic [31:0] dataR;
   logic        en;
   logic        we;

   modport slave (
      input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      input  dataR,
      output m0_gnt, m0_rdata, m0_rvalid,
      output m1_gnt, m1_rdata, m1_rvalid,
      output addr, dataW, en, we
   );

   modport master (
      output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      output dataR,
      input  m0_gnt, m0_rdata, m0_rvalid,
      input  m1_gnt, m1_rdata, m1_rvalid,
      input  addr, dataW, en, we
   );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: two-master arbiter in front of a single-port memory.
// Zero-latency grant (combinational from requests and registered state),
// round-robin on ties, optional locked bursts capped at MAX_BURST cycles.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: IDLE ties always go to m0.
// dbg_state exposes the FSM: 0 = IDLE, 1 = LOCK0, 2 = LOCK1.
module mem_arb #(
   parameter int MAX_BURST = 16
) (
   input  logic       clk,
   input  logic       reset,
   mem_arb_if.slave   bus,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   state_t     state, state_nxt;
   logic       last, last_nxt;        // master that won the most recent IDLE arbitration
   logic [7:0] burst_cnt, burst_cnt_nxt;
   logic [7:0] cnt_inc;
   logic       burst_done;
   logic       tie_to_m0;
   logic       gnt0, gnt1;
   logic       rvalid0, rvalid1;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign tie_to_m0 = 1'b1;
`else
   // last = 1 means m1 won last time, so m0 gets the tie now.
   assign tie_to_m0 = last;
`endif

   // burst_cnt counts locked-state grants after the entering grant; it saturates
   // so it never wraps. A burst ends when this grant brings the count to
   // MAX_BURST-1, giving MAX_BURST granted cycles including the IDLE grant.
   assign cnt_inc    = (burst_cnt == BURST_LAST) ? burst_cnt : burst_cnt + 8'd1;
   assign burst_done = (cnt_inc == BURST_LAST);

   assign dbg_state  = state;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last      <= 1'b1;
         burst_cnt <= 8'd0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end

   // Next-state logic: lock entry/exit, round-robin history, burst counting.
   always_comb begin
      state_nxt     = state;
      last_nxt      = last;
      burst_cnt_nxt = burst_cnt;
      case (state)
         IDLE: begin
            if (gnt0) begin
               last_nxt = 1'b0;
               if (bus.m0_lock) begin
                  state_nxt     = LOCK0;
                  burst_cnt_nxt = 8'd0;
               end
            end else if (gnt1) begin
               last_nxt = 1'b1;
               if (bus.m1_lock) begin
                  state_nxt     = LOCK1;
                  burst_cnt_nxt = 8'd0;
               end
            end
         end
         LOCK0: begin
            if (gnt0) burst_cnt_nxt = cnt_inc;
            if (!bus.m0_req || !bus.m0_lock || burst_done) state_nxt = IDLE;
         end
         LOCK1: begin
            if (gnt1) burst_cnt_nxt = cnt_inc;
            if (!bus.m1_req || !bus.m1_lock || burst_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: grants and the memory-port mux; everything idle during reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (bus.m0_req && bus.m1_req) begin
                  gnt0 = tie_to_m0;
                  gnt1 = !tie_to_m0;
               end else begin
                  gnt0 = bus.m0_req;
                  gnt1 = bus.m1_req;
               end
            end
            LOCK0:   gnt0 = bus.m0_req;
            LOCK1:   gnt1 = bus.m1_req;
            default: ;
         endcase
      end

      bus.m0_gnt = gnt0;
      bus.m1_gnt = gnt1;
      bus.en     = gnt0 | gnt1;
      bus.we     = 1'b0;
      bus.addr   = 16'h0000;
      bus.dataW  = 32'h0000_0000;
      if (gnt0) begin
         bus.we    = bus.m0_we;
         bus.addr  = bus.m0_addr;
         bus.dataW = bus.m0_wdata;
      end else if (gnt1) begin
         bus.we    = bus.m1_we;
         bus.addr  = bus.m1_addr;
         bus.dataW = bus.m1_wdata;
      end

      bus.m0_rdata  = bus.dataR;
      bus.m1_rdata  = bus.dataR;
      // Masking with reset drops a read that was in flight when reset hit.
      bus.m0_rvalid = rvalid0 & ~reset;
      bus.m1_rvalid = rvalid1 & ~reset;
   end

   // Read-return tracking: one pulse on the next cycle for each granted read.
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= gnt0 & ~bus.m0_we;
         rvalid1 <= gnt1 & ~bus.m1_we;
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the arbiter.
module tb_mem_arb;

   localparam int MB = 4;
`ifdef MEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;

   mem_arb_if bus ();

   mem_arb #(.MAX_BURST(MB)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [1:0] exp_q[$];      // expected {m1_rvalid, m0_rvalid} for the next cycle

   // reference model: who owns the port (-1 = free), grants used in the burst
   int owner;
   int used;
   int last_win;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input bit rq0, input bit we0, input bit lk0, input logic [15:0] a0,
                        input logic [31:0] d0, input bit rq1, input bit we1, input bit lk1,
                        input logic [15:0] a1, input logic [31:0] d1, input bit rs);
      bus.m0_req = rq0; bus.m0_we = we0; bus.m0_lock = lk0; bus.m0_addr = a0; bus.m0_wdata = d0;
      bus.m1_req = rq1; bus.m1_we = we1; bus.m1_lock = lk1; bus.m1_addr = a1; bus.m1_wdata = d1;
      bus.dataR  = $urandom;
      reset      = rs;
   endtask

   // One cycle: check combinational outputs mid-cycle, then advance the model.
   task automatic step();
      bit e0, e1, exp_we, g, rq, lk;
      logic [15:0] exp_addr;
      logic [31:0] exp_data;
      logic [1:0]  rv;
      logic [1:0]  exp_st;

      @(negedge clk);
      e0 = 1'b0;
      e1 = 1'b0;
      if (!reset) begin
         if (owner == 0)      e0 = bus.m0_req;
         else if (owner == 1) e1 = bus.m1_req;
         else if (bus.m0_req && bus.m1_req) begin
            if (FIXED || last_win == 1) e0 = 1'b1;
            else                         e1 = 1'b1;
         end else begin
            e0 = bus.m0_req;
            e1 = bus.m1_req;
         end
      end
      exp_we   = e0 ? bus.m0_we    : (e1 ? bus.m1_we    : 1'b0);
      exp_addr = e0 ? bus.m0_addr  : (e1 ? bus.m1_addr  : 16'h0);
      exp_data = e0 ? bus.m0_wdata : (e1 ? bus.m1_wdata : 32'h0);
      rv       = exp_q.pop_front();
      if (reset) rv = 2'b00;
      exp_st   = (owner == 0) ? 2'd1 : ((owner == 1) ? 2'd2 : 2'd0);

      check_eq("m0_gnt",    32'(bus.m0_gnt),    32'(e0));
      check_eq("m1_gnt",    32'(bus.m1_gnt),    32'(e1));
      check_eq("en",        32'(bus.en),        32'(e0 | e1));
      check_eq("we",        32'(bus.we),        32'(exp_we));
      check_eq("addr",      32'(bus.addr),      32'(exp_addr));
      check_eq("dataW",     bus.dataW,          exp_data);
      check_eq("m0_rdata",  bus.m0_rdata,       bus.dataR);
      check_eq("m1_rdata",  bus.m1_rdata,       bus.dataR);
      check_eq("m0_rvalid", 32'(bus.m0_rvalid), 32'(rv[0]));
      check_eq("m1_rvalid", 32'(bus.m1_rvalid), 32'(rv[1]));
      check_eq("state",     32'(dbg_state),     32'(exp_st));

      @(posedge clk);
      if (reset) begin
         owner    = -1;
         used     = 0;
         last_win = 1;
         exp_q.push_back(2'b00);
      end else begin
         exp_q.push_back({e1 & ~bus.m1_we, e0 & ~bus.m0_we});
         if (owner < 0) begin
            if (e0) begin
               last_win = 0;
               if (bus.m0_lock) begin owner = 0; used = 1; end
            end else if (e1) begin
               last_win = 1;
               if (bus.m1_lock) begin owner = 1; used = 1; end
            end
         end else begin
            g  = (owner == 0) ? e0 : e1;
            rq = (owner == 0) ? bus.m0_req  : bus.m1_req;
            lk = (owner == 0) ? bus.m0_lock : bus.m1_lock;
            if (g) used++;
            if (!rq || !lk || used >= MB) owner = -1;
         end
      end
      #1;
   endtask

   // ---------------- sequence ----------------
   initial begin
      owner    = -1;
      used     = 0;
      last_win = 1;
      drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, 1);
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(2'b00);

      // reset cycle with outputs checked, then quiet cycle
      drive(1, 0, 1, 16'h0042, 32'h1, 1, 1, 0, 16'h0043, 32'h2, 1); step();
      drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0);       step();

      // both masters reading, no lock: m0, m1, m0, m1
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 16'(16'h0200 + i), 32'h0, 1, 0, 0, 16'(16'h0300 + i), 32'h0, 0);
         step();
      end
      drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0); step();

      // lone m1 write
      drive(0, 0, 0, 16'h0, 32'h0, 1, 1, 0, 16'h0010, 32'hDEADBEEF, 0); step();
      drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0);           step();

      // reset so m0 wins the tie, then m0 locked burst capped at MB with m1 waiting
      drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, 1); step();
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 1, 16'(16'h0400 + i), 32'h0, 1, 1, 0, 16'h0500, 32'hA5A5_0000, 0);
         step();
      end
      drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0); step();

      // m1 locked burst, lock dropped on its second cycle while m0 requests
      drive(0, 0, 0, 16'h0, 32'h0, 1, 0, 1, 16'h0600, 32'h0, 0); step();
      drive(1, 1, 0, 16'h0700, 32'h77, 1, 0, 0, 16'h0601, 32'h0, 0); step();
      drive(1, 1, 0, 16'h0701, 32'h78, 0, 0, 0, 16'h0, 32'h0, 0);   step();
      drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0);       step();

      // m0 read then reset while the read data is due
      drive(1, 0, 0, 16'h0100, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0); step();
      drive(1, 0, 1, 16'h0101, 32'h0, 1, 0, 0, 16'h0, 32'h0, 1); step();
      drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, 0);    step();

      // ties from reset for three cycles (round-robin or fixed priority)
      drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 16'h0, 32'h0, 1); step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 16'h0800, 32'h0, 1, 0, 0, 16'h0900, 32'h0, 0);
         step();
      end

      // random traffic
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               16'($urandom), $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               16'($urandom), $urandom,
               $urandom_range(0, 49) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: MAX_BURST, default 16, maximum consecutive granted cycles a locked master may hold the memory port (range 2..255).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 m0_req / m1_req  input  1  master request for a memory access this cycle (m0 = edge accelerator, m1 = host loader).
REQ-005 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-006 m0_lock / m1_lock  input  1  request to keep the grant on following cycles (burst).
REQ-007 m0_addr / m1_addr  input  16  word address.
REQ-008 m0_wdata / m1_wdata  input  32  write data.
REQ-009 m0_gnt / m1_gnt  output  1  access accepted this cycle.
REQ-010 m0_rdata / m1_rdata  output  32  read data, valid when the matching rvalid is high.
REQ-011 m0_rvalid / m1_rvalid  output  1  read data for that master's read granted in the previous cycle.
REQ-012 addr  output  16  memory address.
REQ-013 dataW  output  32  memory write data.
REQ-014 dataR  input  32  memory read data, returned one cycle after an en=1, we=0 access.
REQ-015 en  output  1  memory request.
REQ-016 we  output  1  memory write enable.

Function
REQ-017 Grant is combinational from req inputs and registered state; granted access reaches memory in the same cycle (zero added latency).
REQ-018 At most one gnt high per cycle; gnt_x high only if req_x high.
REQ-019 States: IDLE, LOCK0, LOCK1.
REQ-020 IDLE, one requester: grant it.
REQ-021 IDLE, both requesting: grant the master that did not win the most recent arbitration (round-robin via register last; last = 1 after reset, so m0 wins the first tie).
REQ-022 IDLE -> LOCKx when x granted with lock_x = 1; last <= x on every IDLE grant.
REQ-023 LOCKx: gnt_x = req_x; other master never granted.
REQ-024 LOCKx -> IDLE on clock edge where req_x = 0, lock_x = 0, or burst_cnt = MAX_BURST-1; the exit cycle's access by x is still granted.
REQ-025 burst_cnt (8 bits) clears on entry to LOCKx, increments on each granted LOCKx cycle, never wraps past MAX_BURST-1.
REQ-026 After a MAX_BURST exit, a tie in IDLE goes to the other master (last = x).
REQ-027 Memory outputs: en = m0_gnt | m1_gnt; addr, dataW, we muxed from granted master; when no grant: en = 0, we = 0, addr = 0, dataW = 0.
REQ-028 m0_rdata = m1_rdata = dataR (broadcast).
REQ-029 rvalid_x registered: rvalid_x <= gnt_x & ~we_x; exactly one rvalid pulse per granted read.
REQ-030 Back-to-back reads by alternating masters: each rvalid pulse maps to the correct master with no loss.

Reset
REQ-031 On reset: state = IDLE, last = 1, burst_cnt = 0, m0_rvalid = m1_rvalid = 0.
REQ-032 During the reset cycle all gnt, en, we = 0, addr = 0, dataW = 0.
REQ-033 Reset mid-burst or with a read in flight: lock released, pending rvalid discarded (no pulse after reset).

Configuration
REQ-034 Macro MEM_ARB_FIXED_PRIO_EN: when defined, IDLE ties always go to m0 (last ignored) and LOCK1 exit via MAX_BURST still applies; when undefined, round-robin per REQ-021.

Verification
REQ-035 Reset, then m0_req = m1_req = 1, both reads, no lock, 4 cycles -> gnt sequence m0,m1,m0,m1; rvalid follows one cycle later on the same master.
REQ-036 m1 write addr 0x0010 data 0xDEADBEEF alone -> m1_gnt = 1, en = 1, we = 1, addr = 0x0010, dataW = 0xDEADBEEF in same cycle; no rvalid.
REQ-037 MAX_BURST = 4, m0 lock = 1, req held, m1 req held -> m0 granted 4 cycles, then m1 granted 5th cycle.
REQ-038 m1 locked burst, drops lock after 2 cycles while m0 requests -> m1 granted 2 cycles, m0 granted 3rd cycle.
REQ-039 m0 read at addr 0x0100 then reset asserted next cycle -> m0_rvalid stays 0, state IDLE, en = 0 during reset.
REQ-040 MEM_ARB_FIXED_PRIO_EN defined, both requesting, no lock, 3 cycles -> m0 granted all 3; m1_gnt = 0.
